// File: rtl/fetch_unit.sv
`default_nettype none
//==============================================================================
// Module      : fetch_unit
// Description : Instruction fetch stage. Keeps the fetch PC and has at most
//               one request outstanding to the instruction cache. It
//               predecodes each returned word for JAL and conditional
//               branches and uses the branch predictor's answer to choose the
//               next PC. It delivers {inst, PC, pred_taken} to the decoder and
//               redirects to the ROB target on a flush.
// Ports       : clk_in / rst_n_in         clock, async active-low reset
//               rdy_in                    global enable (low = freeze)
//               if_to_ic_* / ic_to_if_*   I-cache request / response
//               if_to_pr_PC, pr_to_if_*   branch predictor lookup
//               dc_to_if_full, if_to_dc_* decoder / instruction queue
//               rob_to_if_*               redirect from the ROB
// Revision    : 1.0 - initial release
//==============================================================================
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic        rdy_in,
    output logic        if_to_ic_valid,
    output logic [31:0] if_to_ic_PC,
    input  logic        ic_to_if_ready,
    input  logic [31:0] ic_to_if_inst,
    output logic [31:0] if_to_pr_PC,
    input  logic        pr_to_if_prediction,
    input  logic        dc_to_if_full,
    output logic        if_to_dc_valid,
    output logic [31:0] if_to_dc_inst,
    output logic [31:0] if_to_dc_PC,
    output logic        if_to_dc_pred_taken,
    input  logic        rob_to_if_flush,
    input  logic [31:0] rob_to_if_target_PC
);

    localparam logic [6:0] c_OP_JAL    = 7'b1101111;
    localparam logic [6:0] c_OP_BRANCH = 7'b1100011;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_hold_inst;
    logic [31:0] r_hold_pc;
    logic        r_hold_pred;
    logic        r_dc_valid;
    logic [31:0] r_dc_inst;
    logic [31:0] r_dc_pc;
    logic        r_dc_pred;

    logic [31:0] w_imm_j;
    logic [31:0] w_imm_b;
    logic [31:0] w_next_pc;
    logic        w_pred_taken;

    // Immediates of the word currently returned by the cache.
    assign w_imm_j = {{11{ic_to_if_inst[31]}}, ic_to_if_inst[31], ic_to_if_inst[19:12],
                      ic_to_if_inst[20], ic_to_if_inst[30:21], 1'b0};
    assign w_imm_b = {{19{ic_to_if_inst[31]}}, ic_to_if_inst[31], ic_to_if_inst[7],
                      ic_to_if_inst[30:25], ic_to_if_inst[11:8], 1'b0};

    // Predecode. Only JAL and conditional branches can leave the sequential
    // path. JALR needs a register value, so it is treated as fall-through.
    always_comb begin
        w_next_pc    = r_pc + 32'd4;
        w_pred_taken = 1'b0;
        case (ic_to_if_inst[6:0])
            c_OP_JAL: begin
                w_next_pc    = r_pc + w_imm_j;
                w_pred_taken = 1'b1;
            end
            c_OP_BRANCH: begin
                w_pred_taken = pr_to_if_prediction;
                if (pr_to_if_prediction) begin
                    w_next_pc = r_pc + w_imm_b;
                end
            end
            default: begin
                w_next_pc    = r_pc + 32'd4;
                w_pred_taken = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state     <= S_IDLE;
            r_pc        <= RESET_PC;
            r_hold_inst <= 32'd0;
            r_hold_pc   <= 32'd0;
            r_hold_pred <= 1'b0;
            r_dc_valid  <= 1'b0;
            r_dc_inst   <= 32'd0;
            r_dc_pc     <= 32'd0;
            r_dc_pred   <= 1'b0;
        end else if (rdy_in) begin
            // Delivery is a single-cycle pulse unless re-asserted below.
            r_dc_valid <= 1'b0;
            if (rob_to_if_flush) begin
                // A flush overrides everything. Any response arriving in this
                // cycle and any held instruction are dropped.
                r_state     <= S_IDLE;
                r_pc        <= rob_to_if_target_PC;
                r_hold_inst <= 32'd0;
                r_hold_pc   <= 32'd0;
                r_hold_pred <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (!dc_to_if_full) begin
                            r_state <= S_WAIT;
                        end
                    end
                    S_WAIT: begin
                        if (ic_to_if_ready) begin
                            r_pc <= w_next_pc;
                            if (!dc_to_if_full) begin
                                r_dc_valid <= 1'b1;
                                r_dc_inst  <= ic_to_if_inst;
                                r_dc_pc    <= r_pc;
                                r_dc_pred  <= w_pred_taken;
                                r_state    <= S_IDLE;
                            end else begin
                                r_hold_inst <= ic_to_if_inst;
                                r_hold_pc   <= r_pc;
                                r_hold_pred <= w_pred_taken;
                                r_state     <= S_HOLD;
                            end
                        end
                    end
                    S_HOLD: begin
                        if (!dc_to_if_full) begin
                            r_dc_valid <= 1'b1;
                            r_dc_inst  <= r_hold_inst;
                            r_dc_pc    <= r_hold_pc;
                            r_dc_pred  <= r_hold_pred;
                            r_state    <= S_IDLE;
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    // Only WAIT has a request outstanding. Leaving WAIT cancels the request.
    assign if_to_ic_valid      = (r_state == S_WAIT);
    assign if_to_ic_PC         = r_pc;
    assign if_to_pr_PC         = r_pc;
    assign if_to_dc_valid      = r_dc_valid;
    assign if_to_dc_inst       = r_dc_inst;
    assign if_to_dc_PC         = r_dc_pc;
    assign if_to_dc_pred_taken = r_dc_pred;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
//==============================================================================
// Module      : tb_fetch_unit
// Description : Directed bench for fetch_unit with a transaction-level model
//               of expected deliveries and next-fetch addresses.
// Revision    : 1.0 - initial release
//==============================================================================
module tb_fetch_unit;

    logic        clk_in = 1'b0;
    logic        rst_n_in;
    logic        rdy_in;
    logic        if_to_ic_valid;
    logic [31:0] if_to_ic_PC;
    logic        ic_to_if_ready;
    logic [31:0] ic_to_if_inst;
    logic [31:0] if_to_pr_PC;
    logic        pr_to_if_prediction;
    logic        dc_to_if_full;
    logic        if_to_dc_valid;
    logic [31:0] if_to_dc_inst;
    logic [31:0] if_to_dc_PC;
    logic        if_to_dc_pred_taken;
    logic        rob_to_if_flush;
    logic [31:0] rob_to_if_target_PC;

    fetch_unit #(.RESET_PC(32'h0)) dut (
        .clk_in              (clk_in),
        .rst_n_in            (rst_n_in),
        .rdy_in              (rdy_in),
        .if_to_ic_valid      (if_to_ic_valid),
        .if_to_ic_PC         (if_to_ic_PC),
        .ic_to_if_ready      (ic_to_if_ready),
        .ic_to_if_inst       (ic_to_if_inst),
        .if_to_pr_PC         (if_to_pr_PC),
        .pr_to_if_prediction (pr_to_if_prediction),
        .dc_to_if_full       (dc_to_if_full),
        .if_to_dc_valid      (if_to_dc_valid),
        .if_to_dc_inst       (if_to_dc_inst),
        .if_to_dc_PC         (if_to_dc_PC),
        .if_to_dc_pred_taken (if_to_dc_pred_taken),
        .rob_to_if_flush     (rob_to_if_flush),
        .rob_to_if_target_PC (rob_to_if_target_PC)
    );

    always #5 clk_in = ~clk_in;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        tk;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] m_pc;
    int          n_vec = 0;
    int          n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Architectural next-PC rule, using integer immediates.
    function automatic void model(input logic [31:0] pc, input logic [31:0] inst,
                                  input logic pred, output logic [31:0] nxt,
                                  output logic tk);
        int imm;
        if (inst[6:0] == 7'b1101111) begin
            imm = (inst[31] ? -(1 << 20) : 0) + (int'(inst[19:12]) << 12)
                + (int'(inst[20]) << 11) + (int'(inst[30:21]) << 1);
            tk  = 1'b1;
            nxt = pc + 32'(imm);
        end else if (inst[6:0] == 7'b1100011) begin
            imm = (inst[31] ? -(1 << 12) : 0) + (int'(inst[7]) << 11)
                + (int'(inst[30:25]) << 5) + (int'(inst[11:8]) << 1);
            tk  = pred;
            nxt = pred ? pc + 32'(imm) : pc + 32'd4;
        end else begin
            tk  = 1'b0;
            nxt = pc + 32'd4;
        end
    endfunction

    // Every delivered instruction must match the oldest expected one.
    always @(negedge clk_in) begin
        if (rst_n_in && rdy_in && if_to_dc_valid) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_dlv: got inst %h pc %h expected no delivery",
                         if_to_dc_inst, if_to_dc_PC);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("dlv_inst", if_to_dc_inst, e.inst);
                chk("dlv_pc",   if_to_dc_PC,   e.pc);
                chk("dlv_pred", {31'd0, if_to_dc_pred_taken}, {31'd0, e.tk});
            end
        end
    end

    // fmode: 0 = normal, 1 = flush together with ready, 2 = flush at HOLD release
    task automatic fetch(input logic [31:0] inst, input logic pred, input int full_cyc,
                         input int fmode, input logic [31:0] tgt,
                         input logic [31:0] exp_next);
        int          t;
        logic [31:0] nxt;
        logic        tk;
        t = 0;
        while (!if_to_ic_valid && t < 20) begin
            @(negedge clk_in);
            t++;
        end
        chk("req_valid", {31'd0, if_to_ic_valid}, 32'd1);
        chk("req_pc", if_to_ic_PC, m_pc);
        chk("pr_pc",  if_to_pr_PC, m_pc);
        model(m_pc, inst, pred, nxt, tk);
        ic_to_if_ready      = 1'b1;
        ic_to_if_inst       = inst;
        pr_to_if_prediction = pred;
        dc_to_if_full       = (full_cyc > 0);
        rob_to_if_flush     = (fmode == 1);
        rob_to_if_target_PC = tgt;
        if (fmode == 0) exp_q.push_back('{inst: inst, pc: m_pc, tk: tk});
        m_pc = (fmode == 0) ? nxt : tgt;
        @(negedge clk_in);
        ic_to_if_ready      = 1'b0;
        rob_to_if_flush     = 1'b0;
        pr_to_if_prediction = 1'b0;
        if (full_cyc > 0) begin
            for (int i = 0; i < full_cyc; i++) begin
                chk("hold_no_dlv", {31'd0, if_to_dc_valid}, 32'd0);
                chk("hold_no_req", {31'd0, if_to_ic_valid}, 32'd0);
                if (i < full_cyc - 1) @(negedge clk_in);
            end
            dc_to_if_full   = 1'b0;
            rob_to_if_flush = (fmode == 2);
            @(negedge clk_in);
            rob_to_if_flush = 1'b0;
        end
        chk("dlv_pulse", {31'd0, if_to_dc_valid}, (fmode == 0) ? 32'd1 : 32'd0);
        chk("idle_no_req", {31'd0, if_to_ic_valid}, 32'd0);
        @(negedge clk_in);
        chk("pulse_end", {31'd0, if_to_dc_valid}, 32'd0);
        chk("next_req", {31'd0, if_to_ic_valid}, 32'd1);
        chk("next_pc", if_to_ic_PC, exp_next);
    endtask

    // Redirect while a request is outstanding, with no response pending.
    task automatic redirect(input logic [31:0] tgt);
        rob_to_if_flush     = 1'b1;
        rob_to_if_target_PC = tgt;
        @(negedge clk_in);
        rob_to_if_flush = 1'b0;
        chk("redir_cancel", {31'd0, if_to_ic_valid}, 32'd0);
        @(negedge clk_in);
        chk("redir_req", {31'd0, if_to_ic_valid}, 32'd1);
        chk("redir_pc", if_to_ic_PC, tgt);
        m_pc = tgt;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n_in            = 1'b0;
        rdy_in              = 1'b1;
        ic_to_if_ready      = 1'b0;
        ic_to_if_inst       = 32'd0;
        pr_to_if_prediction = 1'b0;
        dc_to_if_full       = 1'b0;
        rob_to_if_flush     = 1'b0;
        rob_to_if_target_PC = 32'd0;
        m_pc                = 32'h0;
        repeat (3) @(negedge clk_in);
        chk("rst_ic_valid", {31'd0, if_to_ic_valid}, 32'd0);
        chk("rst_ic_pc",    if_to_ic_PC, 32'h0);
        chk("rst_dc_valid", {31'd0, if_to_dc_valid}, 32'd0);
        chk("rst_dc_inst",  if_to_dc_inst, 32'd0);
        chk("rst_dc_pc",    if_to_dc_PC, 32'd0);
        chk("rst_dc_pred",  {31'd0, if_to_dc_pred_taken}, 32'd0);
        rst_n_in = 1'b1;
        @(negedge clk_in);
        chk("post_rst_req", {31'd0, if_to_ic_valid}, 32'd1);

        // rdy low freezes: a flush presented while frozen has no effect.
        rdy_in              = 1'b0;
        rob_to_if_flush     = 1'b1;
        rob_to_if_target_PC = 32'h500;
        repeat (2) @(negedge clk_in);
        rob_to_if_flush = 1'b0;
        rdy_in          = 1'b1;
        chk("frz_req", {31'd0, if_to_ic_valid}, 32'd1);
        chk("frz_pc",  if_to_ic_PC, 32'h0);

        fetch(32'h00000013, 1'b0, 0, 0, 32'h0, 32'h4);           // NOP
        redirect(32'h0);
        fetch(32'h008000EF, 1'b0, 0, 0, 32'h0, 32'h8);           // JAL +8
        redirect(32'h10);
        fetch(32'h00000863, 1'b1, 0, 0, 32'h0, 32'h20);          // BEQ +16 taken
        redirect(32'h10);
        fetch(32'h00000863, 1'b0, 0, 0, 32'h0, 32'h14);          // BEQ not taken
        redirect(32'h100);
        fetch(32'hFE000CE3, 1'b1, 0, 0, 32'h0, 32'hF8);          // BEQ -8 taken
        redirect(32'h40);
        fetch(32'h000080E7, 1'b1, 0, 0, 32'h0, 32'h44);          // JALR: fall-through
        redirect(32'hFFFFFFFC);
        fetch(32'h00000013, 1'b0, 0, 0, 32'h0, 32'h0);           // wrap
        fetch(32'h00000013, 1'b0, 5, 0, 32'h0, 32'h4);           // full for 5 cycles
        fetch(32'h00000013, 1'b0, 0, 1, 32'h200, 32'h200);       // flush with ready
        fetch(32'h008000EF, 1'b0, 2, 2, 32'h300, 32'h300);       // flush in HOLD
        fetch(32'h00000013, 1'b0, 0, 0, 32'h0, 32'h304);

        repeat (2) @(negedge clk_in);
        chk("queue_drained", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction fetch stage. Holds the architectural fetch PC and issues one request at a time to the instruction cache. Each returned word is predecoded for JAL and conditional branches, and the PC is indexed into the 2-bit branch predictor to choose the next PC. The fetched instruction, its PC and the predicted-taken bit are pushed to the decoder/instruction queue. Redirect on ROB flush.

Parameters:
RESET_PC, 32'h0, fetch PC loaded on reset.

Ports:
clk_in  input  1  clock, rising edge
rst_n_in  input  1  reset, asynchronous, active-low
rdy_in  input  1  global enable; low freezes all registers
if_to_ic_valid  output  1  fetch request outstanding
if_to_ic_PC  output  32  fetch address (= PC register)
ic_to_if_ready  input  1  one-cycle pulse, instruction word valid
ic_to_if_inst  input  32  fetched instruction
if_to_pr_PC  output  32  predictor lookup address (= PC register)
pr_to_if_prediction  input  1  combinational taken prediction for if_to_pr_PC
dc_to_if_full  input  1  downstream queue cannot accept this cycle
if_to_dc_valid  output  1  one-cycle pulse, instruction delivered
if_to_dc_inst  output  32  delivered instruction
if_to_dc_PC  output  32  PC of delivered instruction
if_to_dc_pred_taken  output  1  predicted-taken bit for delivered instruction
rob_to_if_flush  input  1  mispredict/exception redirect
rob_to_if_target_PC  input  32  redirect target

Behaviour:
- Reset (rst_n_in low, async): PC=RESET_PC, state=IDLE, if_to_ic_valid=0, if_to_dc_valid=0, if_to_dc_inst/PC=0, if_to_dc_pred_taken=0, hold registers cleared.
- rdy_in low: no register changes. Consumers are also rdy-gated, so a held if_to_dc_valid counts once.
- States: IDLE, WAIT, HOLD. if_to_ic_valid=1 exactly in WAIT.
- IDLE: if !dc_to_if_full, go to WAIT; otherwise stay in IDLE.
- WAIT: hold if_to_ic_PC stable until ic_to_if_ready. On ready:
  - Sample pr_to_if_prediction for the current PC.
  - Predecode the opcode as defined below.
  - Compute next_PC and pred_taken.
- Predecode:
  - opcode 1101111 (JAL): next = PC + immJ, pred_taken = 1.
  - opcode 1100011 (branch): next = prediction ? PC + immB : PC + 4, pred_taken = prediction.
  - Any other opcode, including JALR: next = PC + 4, pred_taken = 0.
- Immediates: immJ = sext{inst[31],inst[19:12],inst[20],inst[30:21],1'b0}; immB = sext{inst[31],inst[7],inst[30:25],inst[11:8],1'b0}. All additions are 32-bit modulo 2^32 (wrap, no flag).
- On ready in WAIT, if !dc_to_if_full:
  - Next cycle: if_to_dc_valid=1 with inst, PC and pred_taken.
  - PC <= next; state -> IDLE.
  - Net latency: delivery 1 cycle after ready; next request 2 cycles after ready.
- On ready in WAIT, if dc_to_if_full: latch inst/PC/pred_taken into hold registers, PC <= next, state -> HOLD.
- HOLD: when !dc_to_if_full, pulse if_to_dc_valid with held data next cycle and go to IDLE.
- if_to_dc_valid is high for exactly one cycle per delivered instruction. Outside a pulse, data outputs keep their last values.
- Flush (highest priority, any state, including the same cycle as ic_to_if_ready or a HOLD release):
  - PC <= rob_to_if_target_PC; state -> IDLE.
  - Hold registers invalidated; if_to_dc_valid=0 next cycle.
  - The response arriving that cycle is discarded.
  - Deasserting if_to_ic_valid cancels the cache request; the cache contract guarantees no stale ready after cancel.
- Predictor training is not this block's job; the ROB drives the predictor directly.

Test Plan:
- Reset with RESET_PC=0, no stimulus -> all outputs 0, if_to_ic_PC=0; 1 cycle after release with dc_to_if_full=0, if_to_ic_valid=1.
- PC=0x0, cache returns 0x00000013 (NOP) -> if_to_dc_valid pulse next cycle with PC 0x0, pred_taken=0; next request at 0x4.
- PC=0x0, inst 0x008000EF (JAL x1,+8) -> pred_taken=1, next request at 0x8. PC=0x10, inst 0x00000863 (BEQ +16), prediction=1 -> next 0x20; repeat with prediction=0 -> next 0x14.
- PC=0x100, inst 0xFE000CE3 (BEQ -8), prediction=1 -> next 0xF8. PC=0xFFFFFFFC, NOP -> next 0x0 (wrap).
- dc_to_if_full=1 when ready arrives -> no pulse, state HOLD, if_to_ic_valid=0; full stays high 5 cycles, then low -> single pulse with the original inst/PC.
- rob_to_if_flush=1, target 0x200, in the same cycle as ic_to_if_ready -> no delivery; next request at 0x200. Flush in HOLD -> held instruction never delivered.
